// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multiplier:
// reduction-layer count, row count after N layers and layer-to-stage mapping.
package wallace_pkg;

    localparam int unsigned MAX_STAGES = 4;

    // Rows left after applying the given number of 3:2 layers to the given row count.
    function automatic int unsigned rows_after(input int unsigned rows, input int unsigned layers);
        int unsigned r;
        r = rows;
        for (int unsigned i = 0; i < layers; i++) begin
            if (r > 2) r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    function automatic int unsigned num_layers(input int unsigned rows);
        int unsigned r;
        int unsigned n;
        r = rows;
        n = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (r > 2) begin
                r = 2 * (r / 3) + (r % 3);
                n++;
            end
        end
        return n;
    endfunction

    function automatic int unsigned layer_stage(input int unsigned layer, input int unsigned layers,
                                                input int unsigned stages);
        return (layer * stages) / layers;
    endfunction

    // Smallest layer index mapped to the given stage; equals 'layers' past the last stage.
    function automatic int unsigned stage_first_layer(input int unsigned stage,
                                                      input int unsigned layers,
                                                      input int unsigned stages);
        return (stage * layers + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/wallace_csa_layer.sv
// One Wallace reduction layer: every full group of three rows goes through a bitwise
// 3:2 carry-save cell; leftover rows pass straight through, freed rows are zeroed.
module wallace_csa_layer #(
    parameter int unsigned ROWS  = 3,
    parameter int unsigned ROW_W = 16
) (
    input  logic [ROWS-1:0][ROW_W-1:0] rows_in,
    output logic [ROWS-1:0][ROW_W-1:0] rows_out
);

    localparam int unsigned GROUPS = ROWS / 3;
    localparam int unsigned REM    = ROWS % 3;
    localparam int unsigned NOUT   = 2 * GROUPS + REM;

    for (genvar g = 0; g < GROUPS; g++) begin : g_csa
        logic [ROW_W-1:0] x, y, z;
        assign x = rows_in[3*g];
        assign y = rows_in[3*g+1];
        assign z = rows_in[3*g+2];
        assign rows_out[2*g]   = x ^ y ^ z;
        assign rows_out[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
    end

    for (genvar k = 0; k < REM; k++) begin : g_pass
        assign rows_out[2*GROUPS+k] = rows_in[3*GROUPS+k];
    end

    if (NOUT < ROWS) begin : g_zero
        assign rows_out[ROWS-1:NOUT] = '0;
    end

endmodule

// File: rtl/pipelined_wallace_mult.sv
// Pipelined Wallace-tree multiplier with valid/ready handshake and in-flight counter.
// Define WALLACE_SIGNED_EN to add the in_signed port (Baugh-Wooley signed products).
module pipelined_wallace_mult
    import wallace_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef WALLACE_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] M_OUT,
    output logic [2:0]         inflight
);

    localparam int unsigned ROW_W = 2 * WIDTH;
    localparam int unsigned NL    = num_layers(WIDTH);

    typedef logic [WIDTH-1:0][ROW_W-1:0] rows_t;

    logic              advance, in_xfer, out_xfer, is_signed;
    logic [STAGES-1:0] valid_q;
    logic [ROW_W-1:0]  prod_d, prod_q;
    logic [2:0]        inflight_q;
    rows_t             pp;
    rows_t             lin     [NL];
    rows_t             lout    [NL];
    rows_t             stg_in  [STAGES];
    rows_t             stg_out [STAGES];

`ifdef WALLACE_SIGNED_EN
    assign is_signed = in_signed;
`else
    assign is_signed = 1'b0;
`endif

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_valid = valid_q[STAGES-1];
    assign M_OUT     = prod_q;
    assign inflight  = inflight_q;

    // Signed mode inverts terms with exactly one MSB factor; the correction constant
    // 2^WIDTH + 2^(2*WIDTH-1) sits in row 0, whose upper bits are otherwise empty.
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (A[j] & B[i]) ^
                             (is_signed && ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        if (is_signed) begin
            pp[0][WIDTH]   = 1'b1;
            pp[0][ROW_W-1] = 1'b1;
        end
    end

    assign stg_in[0] = pp;

    for (genvar l = 0; l < NL; l++) begin : g_layer
        localparam int unsigned NR = rows_after(WIDTH, l);
        localparam int unsigned ST = layer_stage(l, NL, STAGES);
        logic [NR-1:0][ROW_W-1:0] part;

        if (l == stage_first_layer(ST, NL, STAGES)) begin : g_head
            assign lin[l] = stg_in[ST];
        end else begin : g_chain
            assign lin[l] = lout[l-1];
        end

        wallace_csa_layer #(
            .ROWS  (NR),
            .ROW_W (ROW_W)
        ) u_layer (
            .rows_in  (lin[l][NR-1:0]),
            .rows_out (part)
        );

        if (NR < WIDTH) begin : g_pad
            assign lout[l] = {lin[l][WIDTH-1:NR], part};
        end else begin : g_full
            assign lout[l] = part;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned LF = stage_first_layer(s, NL, STAGES);
        localparam int unsigned LE = stage_first_layer(s + 1, NL, STAGES);

        if (LE > LF) begin : g_out
            assign stg_out[s] = lout[LE-1];
        end else begin : g_bypass
            assign stg_out[s] = stg_in[s];
        end

        if (s < STAGES - 1) begin : g_reg
            rows_t rows_q;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rows_q <= '0;
                end else if (advance) begin
                    rows_q <= stg_out[s];
                end
            end
            assign stg_in[s+1] = rows_q;
        end
    end

    assign prod_d = stg_out[STAGES-1][0] + stg_out[STAGES-1][1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            prod_q  <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
            prod_q <= prod_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            inflight_q <= inflight_q + 3'd1;
        end else if (out_xfer && !in_xfer) begin
            inflight_q <= inflight_q - 3'd1;
        end
    end

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// Directed, table-driven bench for pipelined_wallace_mult (WIDTH=8, STAGES=3).
module tb_pipelined_wallace_mult;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 3;
    localparam int NV = 11;

    logic        CLK = 1'b0;
    logic        RST, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  A, B;
    logic [15:0] M_OUT;
    logic [2:0]  inflight;
`ifdef WALLACE_SIGNED_EN
    logic        in_signed;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipelined_wallace_mult #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
`ifdef WALLACE_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .M_OUT     (M_OUT),
        .inflight  (inflight)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } svec_t;

    vec_t       vecs [NV];
    logic [7:0] ra [256];
    logic [7:0] rb [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   sent, got;
        logic xin;

        vecs[0]  = '{8'h00, 8'h00, 16'h0000};
        vecs[1]  = '{8'h00, 8'h5A, 16'h0000};
        vecs[2]  = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[3]  = '{8'hFF, 8'h01, 16'h00FF};
        vecs[4]  = '{8'h01, 8'hFF, 16'h00FF};
        vecs[5]  = '{8'h80, 8'h80, 16'h4000};
        vecs[6]  = '{8'h0F, 8'h0F, 16'h00E1};
        vecs[7]  = '{8'h12, 8'h34, 16'h03A8};
        vecs[8]  = '{8'hAA, 8'h55, 16'h3872};
        vecs[9]  = '{8'h7F, 8'h02, 16'h00FE};
        vecs[10] = '{8'hC8, 8'h64, 16'h4E20};

        RST = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
`ifdef WALLACE_SIGNED_EN
        in_signed = 1'b0;
`endif
        tick();
        in_valid = 1'b1; A = 8'hFF; B = 8'hFF;  // must be ignored under reset
        tick();
        RST = 1'b0; in_valid = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_m_out", M_OUT, 0);
        chk("reset_inflight", inflight, 0);
        chk("reset_in_ready", in_ready, 1);

        // Table vectors streamed back-to-back: product k appears after edge k+2.
        for (int k = 0; k < NV + 4; k++) begin
            if (k < NV) begin
                in_valid = 1'b1; A = vecs[k].a; B = vecs[k].b;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("tbl_valid", out_valid, (k >= 2 && k - 2 < NV));
            if (k >= 2 && k - 2 < NV) chk("tbl_prod", M_OUT, vecs[k-2].p);
        end

        // Exact latency of a single transfer.
        in_valid = 1'b1; A = 8'hFF; B = 8'hFF;
        tick();
        in_valid = 1'b0;
        chk("lat_c1", out_valid, 0);
        tick();
        chk("lat_c2", out_valid, 0);
        tick();
        chk("lat_c3", out_valid, 1);
        chk("lat_prod", M_OUT, 16'hFE01);
        tick();
        chk("lat_c4", out_valid, 0);

        // 256 random pairs back-to-back.
        for (int i = 0; i < 256; i++) begin
            ra[i] = 8'($urandom_range(0, 255));
            rb[i] = 8'($urandom_range(0, 255));
        end
        for (int k = 0; k < 260; k++) begin
            if (k < 256) begin
                in_valid = 1'b1; A = ra[k]; B = rb[k];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("rnd_valid", out_valid, (k >= 2 && k - 2 < 256));
            if (k >= 2 && k - 2 < 256) chk("rnd_prod", M_OUT, 16'(ra[k-2]) * 16'(rb[k-2]));
            if (k >= 2 && k <= 255) chk("rnd_inflight", inflight, 3);
        end

        // Stall: out_ready low for 5 cycles while 4 pairs are offered.
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; A = vecs[6+sent].a; B = vecs[6+sent].b;
            #1;
            if (c >= 3) chk("stall_in_ready", in_ready, 0);
            xin = in_ready;
            tick();
            if (xin) sent++;
            if (c >= 2) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", M_OUT, vecs[6].p);
            end
        end
        chk("stall_accepted", sent, 3);
        chk("stall_inflight", inflight, 3);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (sent < 4);
            if (sent < 4) begin
                A = vecs[6+sent].a; B = vecs[6+sent].b;
            end
            #1;
            xin = in_valid && in_ready;
            if (out_valid) begin
                if (got < 4) chk("stall_order", M_OUT, vecs[6+got].p);
                got++;
            end
            tick();
            if (xin) sent++;
        end
        in_valid = 1'b0;
        chk("stall_count", got, 4);

        // Reset pulse with two operations in flight.
        in_valid = 1'b1; A = vecs[2].a; B = vecs[2].b;
        tick();
        A = vecs[5].a; B = vecs[5].b;
        tick();
        in_valid = 1'b0;
        chk("rst_pre_inflight", inflight, 2);
        RST = 1'b1; in_valid = 1'b1; A = vecs[3].a; B = vecs[3].b;
        tick();
        RST = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_m_out", M_OUT, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_in_ready", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst_no_stale", out_valid, 0);
        end
        chk("rst_post_inflight", inflight, 0);

        // Simultaneous input and output transfer with two in flight.
        in_valid = 1'b1; A = vecs[7].a; B = vecs[7].b;
        tick();
        A = vecs[8].a; B = vecs[8].b;
        tick();
        in_valid = 1'b0;
        tick();
        chk("both_pre_inflight", inflight, 2);
        chk("both_pre_prod", M_OUT, vecs[7].p);
        in_valid = 1'b1; A = vecs[9].a; B = vecs[9].b;
        #1;
        chk("both_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("both_inflight", inflight, 2);
        chk("both_prod", M_OUT, vecs[8].p);
        tick();
        chk("both_bubble", out_valid, 0);
        tick();
        chk("both_last", M_OUT, vecs[9].p);
        tick();
        tick();
        chk("both_drained", inflight, 0);

`ifdef WALLACE_SIGNED_EN
        begin
            svec_t sv [4];
            sv[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
            sv[1] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
            sv[2] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
            sv[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
            for (int k = 0; k < 8; k++) begin
                if (k < 4) begin
                    in_valid = 1'b1; in_signed = sv[k].sgn; A = sv[k].a; B = sv[k].b;
                end else begin
                    in_valid = 1'b0; in_signed = 1'b0;
                end
                tick();
                chk("sgn_valid", out_valid, (k >= 2 && k - 2 < 4));
                if (k >= 2 && k - 2 < 4) chk("sgn_prod", M_OUT, sv[k-2].p);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_wallace_mult.md
PIPELINED_WALLACE_MULT -- requirements
Module: pipelined_wallace_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 SHALL have parameter STAGES, default 3: number of register stages, legal range 1..4.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts the operand pair this cycle.
REQ-007 SHALL have port A, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port B, input, WIDTH bits: multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the product.
REQ-011 SHALL have port M_OUT, output, 2*WIDTH bits: product.
REQ-012 SHALL have port inflight, output, 3 bits: number of valid operand pairs held inside the block (0..STAGES).

Function
REQ-013 SHALL form WIDTH partial products (A AND B[i]) shifted by i, and reduce them to two rows with 3:2 carry-save layers using Wallace grouping: every full group of three rows is compressed in each layer.
REQ-014 SHALL finish with a 2*WIDTH-bit carry-propagate adder in the last stage, with the product truncated to 2*WIDTH bits.
REQ-015 SHALL distribute the reduction layers across the STAGES register boundaries as evenly as possible; the final stage register drives M_OUT and out_valid directly.
REQ-016 SHALL advance the pipeline only when advance = !out_valid || out_ready; on advance, every stage loads from its predecessor.
REQ-017 SHALL drive in_ready = advance combinationally; a transfer occurs when in_valid && in_ready.
REQ-018 SHALL have a latency of exactly STAGES cycles from transfer to out_valid when out_ready is held high.
REQ-019 SHALL sustain a throughput of one product per cycle.
REQ-020 SHALL, while stalled (out_valid=1, out_ready=0), hold M_OUT, out_valid and all stage contents stable; no product is lost or duplicated.
REQ-021 SHALL load bubbles (valid=0) into stage 1 when in_valid=0 on advance; bubbles are squeezed out only by advance.
REQ-022 SHALL update inflight by +1 on input transfer, by -1 on output transfer, and hold it when both or neither occur.
REQ-023 SHALL produce the correct product at the operand extremes: 0 times x gives 0; all-ones times all-ones gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1.

Reset
REQ-024 SHALL, with RST=1 at a clock edge, clear all stage valid bits, all stage data registers, M_OUT (to 0), out_valid (to 0) and inflight (to 0).
REQ-025 SHALL discard all in-flight operations when reset is asserted mid-operation; no product emerges after reset.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-027 SHALL ignore in_valid during any cycle in which RST=1.

Configuration
REQ-028 SHALL, with macro WALLACE_SIGNED_EN defined, add input port in_signed (1 bit), captured with the operands and carried through the pipeline.
REQ-029 SHALL, when the captured in_signed=1, form Baugh-Wooley two's-complement partial products (inverted MSB terms plus correction constant) and produce a signed 2*WIDTH-bit product; when in_signed=0, produce an unsigned product.
REQ-030 SHALL, without WALLACE_SIGNED_EN, have no in_signed port and be an unsigned-only multiplier; the logic and timing are otherwise identical.

Structure
REQ-031 SHALL place in shared package wallace_pkg: the function computing the number of reduction layers for a given row count, the layer-to-stage mapping function, and the constant MAX_STAGES=4.
REQ-032 SHALL implement one reduction layer as sub-module wallace_csa_layer (parameters: row count, row width), instantiated once per layer and built from the existing CSA cell.
REQ-033 SHALL keep the handshake and inflight logic in pipelined_wallace_mult.

Verification (WIDTH=8, STAGES=3)
REQ-034 SHALL check: A=0xFF, B=0xFF, out_ready=1 -> M_OUT=0xFE01 with out_valid exactly 3 cycles after the transfer.
REQ-035 SHALL check: 256 back-to-back random pairs with out_ready=1 -> one product per cycle, in order, all matching the reference model, and inflight=3 at steady state.
REQ-036 SHALL check: out_ready=0 for 5 cycles while 4 pairs are offered -> in_ready drops once the pipe is full, M_OUT is held stable, and all 4 products appear in order after release.
REQ-037 SHALL check: RST pulsed 1 cycle while inflight=2 -> out_valid=0, M_OUT=0 and inflight=0 on the next cycle, with no stale product afterwards.
REQ-038 SHALL check, with WALLACE_SIGNED_EN: in_signed=1, A=0x80, B=0x80 -> 0x4000; in_signed=1, A=0xFF, B=0x01 -> 0xFFFF; in_signed=0, A=0xFF, B=0x01 -> 0x00FF.
REQ-039 SHALL check: in_valid and an output transfer in the same cycle with inflight=2 -> inflight stays 2.
